serial_operand_sequencer: RTL and testbench

//  Upstream driver for alu_1bit. Accepts two parallel WIDTH-bit operands plus an op code,

---
 rtl/serial_operand_sequencer_if.sv | 36 +++
 rtl/serial_operand_sequencer.sv | 107 ++++++++++
 tb/tb_serial_operand_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_operand_sequencer_if.sv
// Interface bundling the operand channel, the serial ALU link and the
// result channel of the serial operand sequencer.
interface serial_operand_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_sel;
  logic             alu_rs1;
  logic             alu_rs2;
  logic [2:0]       alu_op;
  logic             alu_en;
  logic             alu_start;
  logic             alu_result;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             busy;

  // Environment side: offers operands, hosts the ALU, consumes results.
  modport master (
    output op_valid, op_a, op_b, op_sel, alu_result, res_ready,
    input  op_ready, alu_rs1, alu_rs2, alu_op, alu_en, alu_start,
    input  res_valid, res_data, res_zero, busy
  );

  // Sequencer side.
  modport slave (
    input  op_valid, op_a, op_b, op_sel, alu_result, res_ready,
    output op_ready, alu_rs1, alu_rs2, alu_op, alu_en, alu_start,
    output res_valid, res_data, res_zero, busy
  );
endinterface

// File: rtl/serial_operand_sequencer.sv
// Serial operand sequencer: latches a parallel operand pair, streams it
// LSB-first into a 1-bit ALU and reassembles the lagging serial result into
// a parallel word returned over a valid/ready handshake.
module serial_operand_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                      clk,
  input logic                      rst,
  serial_operand_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [2:0]       op_q;
  logic             last_bit;

  assign last_bit     = (bit_cnt == CNT_W'(WIDTH - 1));
  assign bus.alu_op   = op_q;
  assign bus.res_data = res_sh;
  assign bus.res_zero = (res_sh == '0);

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and per-state handshake/ALU control outputs.
  always_comb begin
    state_next    = state;
    bus.op_ready  = 1'b0;
    bus.alu_en    = 1'b0;
    bus.alu_start = 1'b0;
    bus.alu_rs1   = 1'b0;
    bus.alu_rs2   = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.op_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.op_valid) state_next = SHIFT;
      end
      SHIFT: begin
        bus.alu_en    = 1'b1;
        bus.alu_start = (bit_cnt == '0);
        bus.alu_rs1   = a_sh[0];
        bus.alu_rs2   = b_sh[0];
        if (last_bit) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and shifting; the result shifts in from the MSB so the
  // first ALU bit (one cycle late) ends up in bit 0 after the drain sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      op_q    <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            a_sh    <= bus.op_a;
            b_sh    <= bus.op_b;
            op_q    <= bus.op_sel;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt != '0) res_sh <= {bus.alu_result, res_sh[WIDTH-1:1]};
        end
        DRAIN: begin
          res_sh <= {bus.alu_result, res_sh[WIDTH-1:1]};
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_operand_sequencer.sv
// Scoreboard bench for serial_operand_sequencer paired with a behavioural
// 1-bit ALU (registered result, carry cleared whenever alu_en is low).
module tb_serial_operand_sequencer;
  localparam int WIDTH = 32;
  localparam int LATENCY = WIDTH + 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             zero;
  } exp_t;

  logic clk;
  logic rst;
  logic rst_n;

  serial_operand_sequencer_if #(.WIDTH(WIDTH)) bus();

  serial_operand_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   accept_count = 0;
  logic prev_valid = 1'b0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 1-bit ALU; its active-low reset is tied to the inverted rst.
  assign rst_n = ~rst;
  logic alu_carry;
  logic alu_res_q;
  logic alu_bb;
  logic alu_cin;
  assign bus.alu_result = alu_res_q;
  assign alu_bb  = (bus.alu_op == 3'b001) ? ~bus.alu_rs2 : bus.alu_rs2;
  assign alu_cin = bus.alu_start ? (bus.alu_op == 3'b001) : alu_carry;

  // ALU bit processing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_carry <= 1'b0;
      alu_res_q <= 1'b0;
    end else if (bus.alu_en) begin
      alu_carry <= 1'b0;
      case (bus.alu_op)
        3'b000, 3'b001: begin
          alu_res_q <= bus.alu_rs1 ^ alu_bb ^ alu_cin;
          alu_carry <= (bus.alu_rs1 & alu_bb) | (alu_cin & (bus.alu_rs1 ^ alu_bb));
        end
        3'b010:  alu_res_q <= bus.alu_rs1 ^ bus.alu_rs2;
        3'b011:  alu_res_q <= bus.alu_rs1 & bus.alu_rs2;
        3'b100:  alu_res_q <= bus.alu_rs1 | bus.alu_rs2;
        default: alu_res_q <= 1'b0;
      endcase
    end else begin
      alu_carry <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: tracks accepts, checks latency, pops the scoreboard on each
  // accepted result.
  always @(negedge clk) begin
    cyc++;
    if (bus.op_valid && bus.op_ready) begin
      accept_cyc = cyc;
      accept_count++;
    end
    if (bus.res_valid && !prev_valid)
      checkOutput("latency", WIDTH'(cyc - accept_cyc), WIDTH'(LATENCY));
    prev_valid = bus.res_valid;
    if (bus.res_valid && bus.res_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("res_data", bus.res_data, e.data);
        checkOutput("res_zero", WIDTH'(bus.res_zero), WIDTH'(e.zero));
      end
    end
  end

  // Offers one operand pair and returns #1 after the accept edge.
  task automatic applyStimulus(input logic [2:0] sel, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_data,
                               input bit push);
    bit ok;
    exp_t e;
    ok = 1'b0;
    if (push) begin
      e.data = exp_data;
      e.zero = (exp_data == '0);
      sb_q.push_back(e);
    end
    bus.op_sel   = sel;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.op_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.op_valid = 1'b0;
    bus.op_a     = '1;
    bus.op_b     = '1;
    bus.op_sel   = 3'b111;
    if (!ok) checkOutput("accept_timeout", 1, 0);
  endtask

  // Waits (bounded) until every expected result has been consumed.
  task automatic waitDrain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sb_q.size() == 0 && !bus.res_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) checkOutput("drain_timeout", 1, 0);
  endtask

  // Hard stop in case something wedges the stimulus process.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=%0d expected=0", 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int acc_before;
    bit ok;
    rst           = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sel    = 3'b000;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst_op_ready", WIDTH'(bus.op_ready), 1);
    checkOutput("rst_res_valid", WIDTH'(bus.res_valid), 0);
    checkOutput("rst_alu_en", WIDTH'(bus.alu_en), 0);
    checkOutput("rst_alu_start", WIDTH'(bus.alu_start), 0);
    checkOutput("rst_alu_bits", WIDTH'({bus.alu_rs1, bus.alu_rs2}), 0);
    checkOutput("rst_alu_op", WIDTH'(bus.alu_op), 0);
    checkOutput("rst_res_data", bus.res_data, 0);
    checkOutput("rst_res_zero", WIDTH'(bus.res_zero), 1);
    checkOutput("rst_busy", WIDTH'(bus.busy), 0);

    applyStimulus(3'b000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b1);
    waitDrain();
    applyStimulus(3'b001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1);
    applyStimulus(3'b001, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 1'b1);
    waitDrain();
    applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    applyStimulus(3'b000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b1);
    waitDrain();
    applyStimulus(3'b010, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFF00_5A5A, 1'b1);
    applyStimulus(3'b011, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h00F0_A5A5, 1'b1);
    applyStimulus(3'b100, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b1);
    applyStimulus(3'b111, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h0000_0000, 1'b1);
    waitDrain();

    // Consumer stalls for 5 cycles while a new operand is offered.
    bus.res_ready = 1'b0;
    applyStimulus(3'b000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.res_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) checkOutput("stall_wait_timeout", 1, 0);
    acc_before   = accept_count;
    bus.op_a     = 32'h0000_0007;
    bus.op_b     = 32'h0000_0007;
    bus.op_sel   = 3'b000;
    bus.op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_res_valid", WIDTH'(bus.res_valid), 1);
      checkOutput("stall_res_data", bus.res_data, 32'h2345_6789);
      checkOutput("stall_op_ready", WIDTH'(bus.op_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.op_valid = 1'b0;
    checkOutput("stall_no_accept", WIDTH'(accept_count - acc_before), 0);
    bus.res_ready = 1'b1;
    waitDrain();

    // Reset while streaming bit 10; the discarded op must never report.
    applyStimulus(3'b000, 32'h0000_1234, 32'h0000_4321, 32'h0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_busy", WIDTH'(bus.busy), 0);
    checkOutput("midrst_alu_en", WIDTH'(bus.alu_en), 0);
    checkOutput("midrst_res_valid", WIDTH'(bus.res_valid), 0);
    checkOutput("midrst_op_ready", WIDTH'(bus.op_ready), 1);
    applyStimulus(3'b000, 32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 1'b1);
    waitDrain();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_empty", WIDTH'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
